// File: rtl/nested_ifs_cfg_loader_if.sv
// Config write channel for the nested-if atom configuration loader.
// Carries addressed 32-bit writes with valid/ready handshake.
// master: write source (drives vld/addr/data); slave: loader (drives rdy).
interface nested_ifs_cfg_loader_if #(
  parameter int ADDR_W = 6
);
  logic              i__cfg_vld;
  logic              o__cfg_rdy;
  logic [ADDR_W-1:0] i__cfg_addr;
  logic [31:0]       i__cfg_data;

  modport master (output i__cfg_vld, i__cfg_addr, i__cfg_data, input o__cfg_rdy);
  modport slave  (input i__cfg_vld, i__cfg_addr, i__cfg_data, output o__cfg_rdy);
endinterface

// File: rtl/nested_ifs_cfg_loader.sv
// Purpose: shadow/active configuration banks for the nested-if atom; commit copies shadow to active in a packet-idle cycle.
// Latency: write lands in shadow next edge; commit reaches active at earliest one edge after the request, o__cfg_updated the cycle after.
// Backpressure: o__cfg_rdy low while a commit is pending (up to PEND_MAX cycles, then forced).
// Ports: clk, rst_n, cfg (write channel interface, slave), i__commit, i__pkt_vld,
//   active bank outputs o__cons_*/o__sel_*/o__rel_op*/o__arith_op*, status o__busy/o__cfg_updated/o__cfg_err/o__forced/o__commit_cnt.
// Optional macro NESTED_IFS_CFG_READBACK_EN: adds i__rd_addr / o__rd_data registered shadow readback.
module nested_ifs_cfg_loader #(
  parameter int ADDR_W   = 6,
  parameter int PEND_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  nested_ifs_cfg_loader_if.slave cfg,
  input  logic               i__commit,
  input  logic               i__pkt_vld,
`ifdef NESTED_IFS_CFG_READBACK_EN
  input  logic [ADDR_W-1:0]  i__rd_addr,
  output logic [31:0]        o__rd_data,
`endif
  output logic [31:0] o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6,
  output logic [31:0] o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11,
  output logic        o__sel_1, o__sel_4, o__sel_7, o__sel_10, o__sel_13, o__sel_16, o__sel_19,
  output logic [1:0]  o__sel_2, o__sel_3, o__sel_5, o__sel_6, o__sel_8, o__sel_9, o__sel_11,
  output logic [1:0]  o__sel_12, o__sel_14, o__sel_15, o__sel_17, o__sel_18, o__sel_20, o__sel_21,
  output logic [1:0]  o__rel_op1, o__rel_op2, o__rel_op3,
  output logic        o__arith_op1, o__arith_op2, o__arith_op3, o__arith_op4,
  output logic        o__busy,
  output logic        o__cfg_updated,
  output logic        o__cfg_err,
  output logic        o__forced,
  output logic [CNT_W-1:0] o__commit_cnt
);

  localparam int WAIT_W = $clog2(PEND_MAX + 1);

  typedef enum logic {IDLE, PEND} state_t;

  // Selects come in groups of three: one 2-way followed by two 3-way,
  // so they are held as sel2[g] and sel3[2g], sel3[2g+1].
  logic [10:0][31:0] sh_cons, ac_cons;
  logic [6:0]        sh_sel2, ac_sel2;
  logic [13:0][1:0]  sh_sel3, ac_sel3;
  logic [2:0][1:0]   sh_rel,  ac_rel;
  logic [3:0]        sh_ar,   ac_ar;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cfg_rdy_q;
  logic [1:0]        rst_sync;
  logic              rst_i_n;
  logic              wr_fire;
  logic              wr_mapped;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  assign cfg.o__cfg_rdy = cfg_rdy_q;
  assign wr_fire        = cfg.i__cfg_vld && cfg_rdy_q;
  assign wr_mapped      = cfg.i__cfg_addr < ADDR_W'(39);

  // Shadow bank: each field keeps only the LSBs of the write data.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      sh_cons <= '0;
      sh_sel2 <= '0;
      sh_sel3 <= '0;
      sh_rel  <= '0;
      sh_ar   <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < 11; k++)
        if (cfg.i__cfg_addr == ADDR_W'(k)) sh_cons[k] <= cfg.i__cfg_data;
      for (int g = 0; g < 7; g++) begin
        if (cfg.i__cfg_addr == ADDR_W'(11 + 3*g)) sh_sel2[g]       <= cfg.i__cfg_data[0];
        if (cfg.i__cfg_addr == ADDR_W'(12 + 3*g)) sh_sel3[2*g]     <= cfg.i__cfg_data[1:0];
        if (cfg.i__cfg_addr == ADDR_W'(13 + 3*g)) sh_sel3[2*g + 1] <= cfg.i__cfg_data[1:0];
      end
      for (int k = 0; k < 3; k++)
        if (cfg.i__cfg_addr == ADDR_W'(32 + k)) sh_rel[k] <= cfg.i__cfg_data[1:0];
      for (int k = 0; k < 4; k++)
        if (cfg.i__cfg_addr == ADDR_W'(35 + k)) sh_ar[k] <= cfg.i__cfg_data[0];
    end
  end

  // Commit FSM. No writes are accepted in PEND, so the copy always sees
  // a stable shadow bank and o__cfg_err cannot be set and cleared together.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cfg_rdy_q      <= 1'b1;
      o__busy        <= 1'b0;
      o__cfg_updated <= 1'b0;
      o__cfg_err     <= 1'b0;
      o__forced      <= 1'b0;
      o__commit_cnt  <= '0;
      ac_cons        <= '0;
      ac_sel2        <= '0;
      ac_sel3        <= '0;
      ac_rel         <= '0;
      ac_ar          <= '0;
    end else begin
      o__cfg_updated <= 1'b0;
      if (wr_fire && !wr_mapped) o__cfg_err <= 1'b1;
      case (state)
        IDLE: begin
          if (i__commit) begin
            state     <= PEND;
            wait_cnt  <= '0;
            cfg_rdy_q <= 1'b0;
            o__busy   <= 1'b1;
          end
        end
        PEND: begin
          // Packet-idle takes priority; otherwise force on the last allowed cycle.
          if (!i__pkt_vld || wait_cnt == WAIT_W'(PEND_MAX - 1)) begin
            ac_cons        <= sh_cons;
            ac_sel2        <= sh_sel2;
            ac_sel3        <= sh_sel3;
            ac_rel         <= sh_rel;
            ac_ar          <= sh_ar;
            o__forced      <= i__pkt_vld;
            o__cfg_updated <= 1'b1;
            o__cfg_err     <= 1'b0;
            o__commit_cnt  <= o__commit_cnt + CNT_W'(1);
            state          <= IDLE;
            cfg_rdy_q      <= 1'b1;
            o__busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NESTED_IFS_CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      o__rd_data <= '0;
    end else begin
      o__rd_data <= '0;
      for (int k = 0; k < 11; k++)
        if (i__rd_addr == ADDR_W'(k)) o__rd_data <= sh_cons[k];
      for (int g = 0; g < 7; g++) begin
        if (i__rd_addr == ADDR_W'(11 + 3*g)) o__rd_data <= {31'b0, sh_sel2[g]};
        if (i__rd_addr == ADDR_W'(12 + 3*g)) o__rd_data <= {30'b0, sh_sel3[2*g]};
        if (i__rd_addr == ADDR_W'(13 + 3*g)) o__rd_data <= {30'b0, sh_sel3[2*g + 1]};
      end
      for (int k = 0; k < 3; k++)
        if (i__rd_addr == ADDR_W'(32 + k)) o__rd_data <= {30'b0, sh_rel[k]};
      for (int k = 0; k < 4; k++)
        if (i__rd_addr == ADDR_W'(35 + k)) o__rd_data <= {31'b0, sh_ar[k]};
    end
  end
`endif

  assign {o__cons_11, o__cons_10, o__cons_9, o__cons_8, o__cons_7, o__cons_6,
          o__cons_5, o__cons_4, o__cons_3, o__cons_2, o__cons_1} = ac_cons;
  assign {o__sel_19, o__sel_16, o__sel_13, o__sel_10, o__sel_7, o__sel_4, o__sel_1} = ac_sel2;
  assign {o__sel_21, o__sel_20, o__sel_18, o__sel_17, o__sel_15, o__sel_14, o__sel_12,
          o__sel_11, o__sel_9, o__sel_8, o__sel_6, o__sel_5, o__sel_3, o__sel_2} = ac_sel3;
  assign {o__rel_op3, o__rel_op2, o__rel_op1} = ac_rel;
  assign {o__arith_op4, o__arith_op3, o__arith_op2, o__arith_op1} = ac_ar;

endmodule

// File: tb/tb_nested_ifs_cfg_loader.sv
// Bench for nested_ifs_cfg_loader: reference model of shadow/active banks,
// expected commits queued at request time and compared on o__cfg_updated.
module tb_nested_ifs_cfg_loader;
  localparam int ADDR_W   = 6;
  localparam int PEND_MAX = 4;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i__commit = 1'b0;
  logic i__pkt_vld = 1'b0;
  always #5 clk = ~clk;

  nested_ifs_cfg_loader_if #(.ADDR_W(ADDR_W)) cfg_if ();

  logic [31:0] o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6;
  logic [31:0] o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11;
  logic        o__sel_1, o__sel_4, o__sel_7, o__sel_10, o__sel_13, o__sel_16, o__sel_19;
  logic [1:0]  o__sel_2, o__sel_3, o__sel_5, o__sel_6, o__sel_8, o__sel_9, o__sel_11;
  logic [1:0]  o__sel_12, o__sel_14, o__sel_15, o__sel_17, o__sel_18, o__sel_20, o__sel_21;
  logic [1:0]  o__rel_op1, o__rel_op2, o__rel_op3;
  logic        o__arith_op1, o__arith_op2, o__arith_op3, o__arith_op4;
  logic        o__busy, o__cfg_updated, o__cfg_err, o__forced;
  logic [CNT_W-1:0] o__commit_cnt;

  nested_ifs_cfg_loader #(.ADDR_W(ADDR_W), .PEND_MAX(PEND_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if), .i__commit(i__commit), .i__pkt_vld(i__pkt_vld),
    .o__cons_1(o__cons_1), .o__cons_2(o__cons_2), .o__cons_3(o__cons_3), .o__cons_4(o__cons_4),
    .o__cons_5(o__cons_5), .o__cons_6(o__cons_6), .o__cons_7(o__cons_7), .o__cons_8(o__cons_8),
    .o__cons_9(o__cons_9), .o__cons_10(o__cons_10), .o__cons_11(o__cons_11),
    .o__sel_1(o__sel_1), .o__sel_4(o__sel_4), .o__sel_7(o__sel_7), .o__sel_10(o__sel_10),
    .o__sel_13(o__sel_13), .o__sel_16(o__sel_16), .o__sel_19(o__sel_19),
    .o__sel_2(o__sel_2), .o__sel_3(o__sel_3), .o__sel_5(o__sel_5), .o__sel_6(o__sel_6),
    .o__sel_8(o__sel_8), .o__sel_9(o__sel_9), .o__sel_11(o__sel_11), .o__sel_12(o__sel_12),
    .o__sel_14(o__sel_14), .o__sel_15(o__sel_15), .o__sel_17(o__sel_17), .o__sel_18(o__sel_18),
    .o__sel_20(o__sel_20), .o__sel_21(o__sel_21),
    .o__rel_op1(o__rel_op1), .o__rel_op2(o__rel_op2), .o__rel_op3(o__rel_op3),
    .o__arith_op1(o__arith_op1), .o__arith_op2(o__arith_op2),
    .o__arith_op3(o__arith_op3), .o__arith_op4(o__arith_op4),
    .o__busy(o__busy), .o__cfg_updated(o__cfg_updated), .o__cfg_err(o__cfg_err),
    .o__forced(o__forced), .o__commit_cnt(o__commit_cnt)
  );

  // DUT active bank viewed in address order.
  logic [31:0] dut_f [39];
  assign dut_f[0] = o__cons_1;   assign dut_f[1] = o__cons_2;   assign dut_f[2] = o__cons_3;
  assign dut_f[3] = o__cons_4;   assign dut_f[4] = o__cons_5;   assign dut_f[5] = o__cons_6;
  assign dut_f[6] = o__cons_7;   assign dut_f[7] = o__cons_8;   assign dut_f[8] = o__cons_9;
  assign dut_f[9] = o__cons_10;  assign dut_f[10] = o__cons_11;
  assign dut_f[11] = {31'b0, o__sel_1};  assign dut_f[12] = {30'b0, o__sel_2};
  assign dut_f[13] = {30'b0, o__sel_3};  assign dut_f[14] = {31'b0, o__sel_4};
  assign dut_f[15] = {30'b0, o__sel_5};  assign dut_f[16] = {30'b0, o__sel_6};
  assign dut_f[17] = {31'b0, o__sel_7};  assign dut_f[18] = {30'b0, o__sel_8};
  assign dut_f[19] = {30'b0, o__sel_9};  assign dut_f[20] = {31'b0, o__sel_10};
  assign dut_f[21] = {30'b0, o__sel_11}; assign dut_f[22] = {30'b0, o__sel_12};
  assign dut_f[23] = {31'b0, o__sel_13}; assign dut_f[24] = {30'b0, o__sel_14};
  assign dut_f[25] = {30'b0, o__sel_15}; assign dut_f[26] = {31'b0, o__sel_16};
  assign dut_f[27] = {30'b0, o__sel_17}; assign dut_f[28] = {30'b0, o__sel_18};
  assign dut_f[29] = {31'b0, o__sel_19}; assign dut_f[30] = {30'b0, o__sel_20};
  assign dut_f[31] = {30'b0, o__sel_21};
  assign dut_f[32] = {30'b0, o__rel_op1}; assign dut_f[33] = {30'b0, o__rel_op2};
  assign dut_f[34] = {30'b0, o__rel_op3};
  assign dut_f[35] = {31'b0, o__arith_op1}; assign dut_f[36] = {31'b0, o__arith_op2};
  assign dut_f[37] = {31'b0, o__arith_op3}; assign dut_f[38] = {31'b0, o__arith_op4};

  typedef struct {
    logic [511:0] v;
    logic         f;
    logic [15:0]  c;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [39];   // shadow model
  logic [31:0] act [39];   // active model
  int          mcnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int a);
    if (a < 11) return 32;
    if (a < 32) return ((a - 11) % 3 == 0) ? 1 : 2;
    if (a < 35) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] fld(input int a, input logic [31:0] d);
    if (wid(a) == 32) return d;
    return d & ((32'd1 << wid(a)) - 32'd1);
  endfunction

  function automatic logic [511:0] pack(input logic [31:0] f [39]);
    logic [511:0] v = '0;
    for (int a = 0; a < 39; a++) v = (v << wid(a)) | {480'b0, fld(a, f[a])};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic f);
    exp_t e;
    mcnt++;
    act  = mdl;
    e.v  = pack(mdl);
    e.f  = f;
    e.c  = 16'(mcnt);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    chk("drain", 512'(sb_q.size()), 0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    chk("wr_rdy", cfg_if.o__cfg_rdy, 1);
    cfg_if.i__cfg_vld = 1'b1; cfg_if.i__cfg_addr = 6'(a); cfg_if.i__cfg_data = d;
    tick();
    cfg_if.i__cfg_vld = 1'b0;
    if (a < 39) mdl[a] = fld(a, d);
    else chk("err_set", o__cfg_err, 1);
    chk("wr_no_leak", pack(dut_f), pack(act));
  endtask

  // Commit in a packet-idle cycle, optionally with a write in the request cycle.
  task automatic commit_idle(input bit with_wr, input int a, input logic [31:0] d);
    i__commit = 1'b1; i__pkt_vld = 1'b0;
    if (with_wr) begin
      cfg_if.i__cfg_vld = 1'b1; cfg_if.i__cfg_addr = 6'(a); cfg_if.i__cfg_data = d;
    end
    tick();
    i__commit = 1'b0; cfg_if.i__cfg_vld = 1'b0;
    if (with_wr) mdl[a] = fld(a, d);
    chk("lat_hold", pack(dut_f), pack(act));
    chk("busy", o__busy, 1);
    chk("pend_rdy", cfg_if.o__cfg_rdy, 0);
    push_exp(1'b0);
    tick();
    chk("lat_upd", o__cfg_updated, 1);
    chk("idle_rdy", cfg_if.o__cfg_rdy, 1);
    tick();
    chk("upd_pulse", o__cfg_updated, 0);
    wait_drain();
  endtask

  task automatic commit_forced();
    i__commit = 1'b1; i__pkt_vld = 1'b1;
    tick();
    i__commit = 1'b0;
    chk("frc_rdy0", cfg_if.o__cfg_rdy, 0);
    for (int k = 1; k < PEND_MAX; k++) begin
      i__commit = (k == 1);   // ignored while pending
      tick();
      i__commit = 1'b0;
      chk("frc_rdy", cfg_if.o__cfg_rdy, 0);
      chk("frc_busy", o__busy, 1);
    end
    push_exp(1'b1);
    tick();
    chk("frc_done_rdy", cfg_if.o__cfg_rdy, 1);
    chk("frc_flag", o__forced, 1);
    i__pkt_vld = 1'b0;
    wait_drain();
    repeat (3) tick();
    chk("frc_no_recommit", 512'(o__commit_cnt), 512'(16'(mcnt)));
  endtask

  // Scoreboard side: compare each committed bank when the DUT announces it.
  always begin
    @(posedge clk);
    #1;
    if (rst_n && o__cfg_updated) begin
      if (sb_q.size() == 0) begin
        chk("spurious_upd", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("active", pack(dut_f), e.v);
        chk("forced", o__forced, e.f);
        chk("cnt", 512'(o__commit_cnt), 512'(e.c));
        chk("err_clr", o__cfg_err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dd;
    int aa;
    cfg_if.i__cfg_vld = 1'b0; cfg_if.i__cfg_addr = '0; cfg_if.i__cfg_data = '0;
    for (int a = 0; a < 39; a++) begin mdl[a] = '0; act[a] = '0; end
    mcnt = 0;

    repeat (3) tick();
    chk("rst_bank", pack(dut_f), 0);
    chk("rst_rdy", cfg_if.o__cfg_rdy, 1);
    chk("rst_busy", o__busy, 0);
    chk("rst_upd", o__cfg_updated, 0);
    chk("rst_err", o__cfg_err, 0);
    chk("rst_forced", o__forced, 0);
    chk("rst_cnt", 512'(o__commit_cnt), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: writes without commit leave active bank untouched
    wr(0, 32'hDEADBEEF);
    wr(11, 32'h1);
    chk("t1_cons1", o__cons_1, 0);
    chk("t1_sel1", o__sel_1, 0);
    chk("t1_cnt", 512'(o__commit_cnt), 0);

    // 2: idle commit
    commit_idle(1'b0, 0, 0);
    chk("t2_cons1", o__cons_1, 32'hDEADBEEF);
    chk("t2_sel1", o__sel_1, 1);
    chk("t2_cnt", 512'(o__commit_cnt), 1);
    chk("t2_forced", o__forced, 0);

    // 3: truncation and unmapped write
    wr(12, 32'hFFFFFFFF);
    wr(40, 32'h12345678);
    chk("t3_err_sticky", o__cfg_err, 1);
    commit_idle(1'b0, 0, 0);
    chk("t3_sel2", o__sel_2, 2'b11);
    chk("t3_err_clr", o__cfg_err, 0);

    // 4: forced commit, then a clean commit clears o__forced
    wr(1, 32'hCAFEF00D);
    commit_forced();
    chk("t4_cons2", o__cons_2, 32'hCAFEF00D);
    wr(2, 32'h00000055);
    commit_idle(1'b0, 0, 0);
    chk("t4_forced_clr", o__forced, 0);

    // 5: write in the same cycle as the commit request is included
    commit_idle(1'b1, 32, 32'h3);
    chk("t5_rel1", o__rel_op1, 2'd3);

    // mixed fields with random data
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 4; w++) begin
        aa = $urandom_range(0, 40);
        dd = $urandom;
        wr(aa, dd);
      end
      commit_idle(1'b0, 0, 0);
    end

    // 6: reset while pending
    i__commit = 1'b1; i__pkt_vld = 1'b1;
    tick();
    i__commit = 1'b0;
    tick();
    chk("t6_busy_before", o__busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_bank", pack(dut_f), 0);
    chk("t6_cons1", o__cons_1, 0);
    chk("t6_busy", o__busy, 0);
    chk("t6_cnt", 512'(o__commit_cnt), 0);
    chk("t6_forced", o__forced, 0);
    chk("t6_upd", o__cfg_updated, 0);
    for (int a = 0; a < 39; a++) begin mdl[a] = '0; act[a] = '0; end
    mcnt = 0;
    i__pkt_vld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_idle", o__busy, 0);
    // shadow must also have been cleared: commit it and expect all zero
    commit_idle(1'b0, 0, 0);
    chk("t6_cnt_after", 512'(o__commit_cnt), 1);

    repeat (3) tick();
    chk("sb_empty", 512'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nested_ifs_cfg_loader.md
Name: nested_ifs_cfg_loader

Overview:
Upstream configuration stage for the nested-if stateful atom. It accepts addressed 32-bit writes into a shadow bank of all atom configuration fields: 11 constants, 21 mux selects, 3 relational opcodes and 4 arithmetic opcodes. On request it commits the shadow bank atomically to an active bank, but only in a packet-idle cycle. The active bank drives the atom's i__cons_*/i__sel_*/i__rel_op*/i__arith_op* inputs directly, so the atom never sees a half-written configuration.

Parameters:
ADDR_W, 6, config address width; field map occupies 0..38.
PEND_MAX, 255, maximum cycles a commit waits for a packet-idle cycle before it is forced.
CNT_W, 16, width of the commit counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i__cfg_vld  input  1  config write valid
o__cfg_rdy  output  1  config write ready
i__cfg_addr  input  ADDR_W  field address
i__cfg_data  input  32  write data; truncated to field width, LSBs kept
i__commit  input  1  commit request, single-cycle pulse
i__pkt_vld  input  1  packet presented to atom this cycle
o__cons_1..o__cons_11  output  32 each  active constants
o__sel_1,4,7,10,13,16,19  output  1 each  active 2-way selects
o__sel_2,3,5,6,8,9,11,12,14,15,17,18,20,21  output  2 each  active 3-way selects
o__rel_op1..o__rel_op3  output  2 each  active relational opcodes
o__arith_op1..o__arith_op4  output  1 each  active arithmetic opcodes
o__busy  output  1  commit pending
o__cfg_updated  output  1  one-cycle pulse, cycle after active bank changes
o__cfg_err  output  1  sticky: write to unmapped address
o__forced  output  1  sticky: last commit forced by timeout
o__commit_cnt  output  CNT_W  number of completed commits, wraps

Behaviour:
- Address map: 0..10 = cons_1..cons_11; 11..31 = sel_1..sel_21; 32..34 = rel_op1..rel_op3; 35..38 = arith_op1..arith_op4; 39 and above are unmapped.
- Reset (async assert, release synchronised to clk): shadow and active banks all zero; o__cfg_rdy=1; o__busy=0; o__cfg_updated=0; o__cfg_err=0; o__forced=0; o__commit_cnt=0; state IDLE.
- A write transfers when i__cfg_vld && o__cfg_rdy. It updates the shadow bank at the next edge. Active outputs are unaffected until a commit.
- An unmapped write is accepted and discarded, and sets o__cfg_err.
- FSM IDLE: o__cfg_rdy=1. i__commit=1 moves to PEND and clears the wait counter. A write in the same cycle as i__commit lands in shadow and is included in the commit.
- FSM PEND: o__cfg_rdy=0, o__busy=1, and i__commit is ignored.
  - In the first PEND cycle with i__pkt_vld=0, shadow is copied to active at that edge and the FSM returns to IDLE.
  - If the wait counter reaches PEND_MAX while i__pkt_vld is still 1, the copy is forced at that edge, o__forced is set, and the FSM returns to IDLE.
  - A non-forced commit clears o__forced.
- Every commit, normal or forced: o__cfg_updated pulses high for exactly the following cycle; o__commit_cnt increments and wraps to 0 from all-ones; o__cfg_err clears.
- Minimum commit latency: i__commit at cycle N with i__pkt_vld=0 at N+1 gives active outputs changed after edge N+1, and o__cfg_updated high during N+2.
- Reset asserted mid-PEND: the commit is abandoned and both banks are zeroed.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
NESTED_IFS_CFG_READBACK_EN
- Defined: adds input i__rd_addr (ADDR_W) and output o__rd_data (32).
  - o__rd_data returns the zero-extended shadow field one cycle after the address is presented.
  - An unmapped address returns 32'h0.
  - Readback is unaffected by FSM state.
- Undefined: neither port exists and no readback mux is built.

Test Plan:
1. Reset, then write addr 0 = 32'hDEADBEEF and addr 11 = 1 with no commit -> o__cons_1=0 and o__sel_1=0 held; o__commit_cnt=0.
2. Writes as in test 1, then i__commit with i__pkt_vld=0 -> after the edge o__cons_1=32'hDEADBEEF and o__sel_1=1; o__cfg_updated high one cycle; o__commit_cnt=1; o__forced=0.
3. Write addr 12 = 32'hFFFFFFFF -> o__sel_2=2'b11 after commit (truncation). Write addr 40 -> o__cfg_err=1, shadow unchanged, and o__cfg_err clears on the next commit.
4. i__commit with i__pkt_vld held 1 and PEND_MAX=4 -> o__cfg_rdy=0 for the wait; forced copy after 4 cycles; o__forced=1. A following commit made in a packet-idle cycle clears o__forced.
5. Write addr 32 = 3 in the same cycle as i__commit -> the committed o__rel_op1=3.
6. i__commit, then assert rst_n=0 during PEND with i__pkt_vld=1 -> all outputs zero immediately, o__busy=0, o__commit_cnt=0.
